// File: rtl/hms_pkg.sv
// Shared encodings for the H:M:S timekeeper: mode, edit position and ring state.
// HMS_SNOOZE_EN adds the SNOOZE ring state.
package hms_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SETUP = 2'b01,
        MODE_ALARM = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'b00,
        POS_MIN  = 2'b01,
        POS_HOUR = 2'b10
    } pos_t;

`ifdef HMS_SNOOZE_EN
    typedef enum logic [1:0] {
        RING_IDLE   = 2'b00,
        RING_RING   = 2'b01,
        RING_SNOOZE = 2'b10
    } ring_t;
`else
    typedef enum logic [1:0] {
        RING_IDLE = 2'b00,
        RING_RING = 2'b01
    } ring_t;
`endif

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

endpackage

// File: rtl/hms_field.sv
// One wrapping time/alarm field: counts 0..MAX on inc_en, clr forces 0.
// carry flags the wrap so the next field up can advance in the same cycle.
module hms_field #(
    parameter int unsigned MAX   = 59,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_nxt,
    output logic             carry
);

    // Next value: clear beats increment; anything at or above MAX wraps to 0.
    always_comb begin
        value_nxt = value;
        if (clr) begin
            value_nxt = '0;
        end else if (inc_en) begin
            value_nxt = (value >= WIDTH'(MAX)) ? '0 : value + 1'b1;
        end
    end

    assign carry = inc_en && (value == WIDTH'(MAX));

    // Field register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/hms_timekeeper.sv
// H:M:S timekeeper with setup and alarm ring FSM, single clock domain.
// Optional feature macro: HMS_SNOOZE_EN (ring action snoozes instead of stopping).
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned HOUR_MAX   = 23,
    parameter int unsigned RING_SEC   = 30,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pls,
    input  logic       i_pos_pls,
    input  logic       i_inc_pls,
    input  logic       i_alarm_en,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_mode,
    output logic [1:0] o_pos,
    output logic       o_ring,
    output logic       o_tick
);

    localparam int unsigned PW         = $clog2(TICK_DIV);
    localparam int unsigned RW         = $clog2(RING_SEC + 1);
    localparam int unsigned SNZ_TICKS  = SNOOZE_MIN * 60;

    if (TICK_DIV < 2 || HOUR_MAX < 1 || HOUR_MAX > 31 || RING_SEC < 1 || SNOOZE_MIN < 1) begin : g_bad_param
        $error("hms_timekeeper: parameter out of range");
    end

    mode_t        mode_q;
    pos_t         pos_q;
    ring_t        ring_q;
    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] ring_cnt;
    logic          ring_out;
    logic          tick;

    logic mode_go, pos_go, inc_go;
    logic edit_time, edit_alarm, ring_act, alarm_hit;

    logic [5:0] t_sec, t_min, a_sec, a_min;
    logic [4:0] t_hour, a_hour;
    logic [5:0] t_sec_nxt, t_min_nxt, a_sec_nxt, a_min_nxt;
    logic [4:0] t_hour_nxt, a_hour_nxt;
    logic       t_sec_co, t_min_co, t_hour_co, a_sec_co, a_min_co, a_hour_co;
    logic       unused_ok;

    // Pulse priority: mode beats position beats increment.
    assign mode_go = i_mode_pls;
    assign pos_go  = i_pos_pls && !i_mode_pls;
    assign inc_go  = i_inc_pls && !i_mode_pls && !i_pos_pls;

    assign edit_time  = inc_go && (mode_q == MODE_SETUP);
    assign edit_alarm = inc_go && (mode_q == MODE_ALARM);
    assign ring_act   = inc_go && (mode_q == MODE_CLOCK);

    // Second prescaler; parked at 0 while in SETUP so time is frozen there.
    assign tick = (mode_q != MODE_SETUP) && (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (mode_q == MODE_SETUP || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Mode and edit-position FSM; illegal codes recover, any mode change homes pos.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_CLOCK;
            pos_q  <= POS_SEC;
        end else begin
            case (mode_q)
                MODE_CLOCK: if (mode_go) mode_q <= MODE_SETUP;
                MODE_SETUP: if (mode_go) mode_q <= MODE_ALARM;
                MODE_ALARM: if (mode_go) mode_q <= MODE_CLOCK;
                default:    mode_q <= MODE_CLOCK;
            endcase

            if (mode_go || !(mode_q inside {MODE_CLOCK, MODE_SETUP, MODE_ALARM})) begin
                pos_q <= POS_SEC;
            end else begin
                case (pos_q)
                    POS_SEC:  if (pos_go) pos_q <= POS_MIN;
                    POS_MIN:  if (pos_go) pos_q <= POS_HOUR;
                    POS_HOUR: if (pos_go) pos_q <= POS_SEC;
                    default:  pos_q <= POS_SEC;
                endcase
            end
        end
    end

    // Time fields: the carry is qualified by tick so SETUP edits never ripple upward.
    hms_field #(.MAX(SEC_MAX), .WIDTH(6)) u_t_sec (
        .clk(clk), .rst_n(rst_n),
        .inc_en(tick || (edit_time && pos_q == POS_SEC)), .clr(1'b0),
        .value(t_sec), .value_nxt(t_sec_nxt), .carry(t_sec_co)
    );
    hms_field #(.MAX(MIN_MAX), .WIDTH(6)) u_t_min (
        .clk(clk), .rst_n(rst_n),
        .inc_en((tick && t_sec_co) || (edit_time && pos_q == POS_MIN)), .clr(1'b0),
        .value(t_min), .value_nxt(t_min_nxt), .carry(t_min_co)
    );
    hms_field #(.MAX(HOUR_MAX), .WIDTH(5)) u_t_hour (
        .clk(clk), .rst_n(rst_n),
        .inc_en((tick && t_min_co) || (edit_time && pos_q == POS_HOUR)), .clr(1'b0),
        .value(t_hour), .value_nxt(t_hour_nxt), .carry(t_hour_co)
    );

    // Alarm fields: edited independently, no carries.
    hms_field #(.MAX(SEC_MAX), .WIDTH(6)) u_a_sec (
        .clk(clk), .rst_n(rst_n),
        .inc_en(edit_alarm && pos_q == POS_SEC), .clr(1'b0),
        .value(a_sec), .value_nxt(a_sec_nxt), .carry(a_sec_co)
    );
    hms_field #(.MAX(MIN_MAX), .WIDTH(6)) u_a_min (
        .clk(clk), .rst_n(rst_n),
        .inc_en(edit_alarm && pos_q == POS_MIN), .clr(1'b0),
        .value(a_min), .value_nxt(a_min_nxt), .carry(a_min_co)
    );
    hms_field #(.MAX(HOUR_MAX), .WIDTH(5)) u_a_hour (
        .clk(clk), .rst_n(rst_n),
        .inc_en(edit_alarm && pos_q == POS_HOUR), .clr(1'b0),
        .value(a_hour), .value_nxt(a_hour_nxt), .carry(a_hour_co)
    );

    assign unused_ok = &{1'b0, t_hour_co, a_sec_co, a_min_co, a_hour_co,
                         a_sec_nxt, a_min_nxt, a_hour_nxt};

    // Match on the post-tick time so o_ring rises together with the matching display.
    assign alarm_hit = tick && (t_hour_nxt == a_hour) && (t_min_nxt == a_min) && (t_sec_nxt == a_sec);

`ifdef HMS_SNOOZE_EN
    localparam int unsigned SW = $clog2(SNZ_TICKS + 1);
    logic [SW-1:0] snz_cnt;
`endif

    // Ring FSM with registered o_ring; disarming wins from every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q   <= RING_IDLE;
            ring_cnt <= '0;
            ring_out <= 1'b0;
`ifdef HMS_SNOOZE_EN
            snz_cnt  <= '0;
`endif
        end else if (!i_alarm_en) begin
            ring_q   <= RING_IDLE;
            ring_cnt <= '0;
            ring_out <= 1'b0;
        end else begin
            case (ring_q)
                RING_IDLE: begin
                    if (alarm_hit) begin
                        ring_q   <= RING_RING;
                        ring_cnt <= '0;
                        ring_out <= 1'b1;
                    end
                end
                RING_RING: begin
                    if (ring_act) begin
`ifdef HMS_SNOOZE_EN
                        ring_q  <= RING_SNOOZE;
                        snz_cnt <= '0;
`else
                        ring_q  <= RING_IDLE;
`endif
                        ring_out <= 1'b0;
                    end else if (tick) begin
                        if (ring_cnt == RW'(RING_SEC - 1)) begin
                            ring_q   <= RING_IDLE;
                            ring_out <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
`ifdef HMS_SNOOZE_EN
                RING_SNOOZE: begin
                    if (tick) begin
                        if (snz_cnt == SW'(SNZ_TICKS - 1)) begin
                            ring_q   <= RING_RING;
                            ring_cnt <= '0;
                            ring_out <= 1'b1;
                        end else begin
                            snz_cnt <= snz_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    ring_q   <= RING_IDLE;
                    ring_out <= 1'b0;
                end
            endcase
        end
    end

    // Display mux: alarm registers in ALARM mode, time registers otherwise.
    always_comb begin
        o_sec  = t_sec;
        o_min  = t_min;
        o_hour = t_hour;
        if (mode_q == MODE_ALARM) begin
            o_sec  = a_sec;
            o_min  = a_min;
            o_hour = a_hour;
        end
    end

    assign o_mode = mode_q;
    assign o_pos  = pos_q;
    assign o_ring = ring_out;
    assign o_tick = tick;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed + random bench for hms_timekeeper; reference model keeps time as
// seconds-of-day and ring timing as remaining-tick counts.
module tb_hms_timekeeper;

    localparam int TD  = 4;
    localparam int HM  = 23;
    localparam int RS  = 3;
    localparam int SM  = 1;
    localparam int DAY = (HM + 1) * 3600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_mode_pls = 1'b0;
    logic       i_pos_pls = 1'b0;
    logic       i_inc_pls = 1'b0;
    logic       i_alarm_en = 1'b0;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [1:0] o_mode, o_pos;
    logic       o_ring, o_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_time = 0, m_alarm = 0, m_mode = 0, m_pos = 0, m_phase = 0, m_ring = 0, m_left = 0;

    hms_timekeeper #(
        .TICK_DIV(TD), .HOUR_MAX(HM), .RING_SEC(RS), .SNOOZE_MIN(SM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mode_pls(i_mode_pls), .i_pos_pls(i_pos_pls), .i_inc_pls(i_inc_pls),
        .i_alarm_en(i_alarm_en),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_mode(o_mode), .o_pos(o_pos), .o_ring(o_ring), .o_tick(o_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int edit(input int t, input int p);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        case (p)
            0:       s = (s + 1) % 60;
            1:       m = (m + 1) % 60;
            default: h = (h + 1) % (HM + 1);
        endcase
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic int disp();
        return (m_mode == 2) ? m_alarm : m_time;
    endfunction

    // One clock cycle: drive pulses, check o_tick, advance model, compare outputs.
    task automatic cycle(input bit mp, input bit pp, input bit ip);
        bit tk, mgo, pgo, igo;
        int nt, na, dv;
        i_mode_pls = mp;
        i_pos_pls  = pp;
        i_inc_pls  = ip;
        #1;
        tk  = (m_mode != 1) && (m_phase == TD - 1);
        check("tick", o_tick, tk);
        mgo = mp;
        pgo = pp && !mp;
        igo = ip && !mp && !pp;
        nt = m_time;
        if (tk) nt = (nt + 1) % DAY;
        if (m_mode == 1 && igo) nt = edit(nt, m_pos);
        na = m_alarm;
        if (m_mode == 2 && igo) na = edit(na, m_pos);
        if (!i_alarm_en) begin
            m_ring = 0;
        end else if (m_ring == 0) begin
            if (tk && nt == m_alarm) begin m_ring = 1; m_left = RS; end
        end else if (m_ring == 1) begin
            if (m_mode == 0 && igo) begin
`ifdef HMS_SNOOZE_EN
                m_ring = 2; m_left = SM * 60;
`else
                m_ring = 0;
`endif
            end else if (tk) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
        end else begin
            if (tk) begin
                m_left--;
                if (m_left == 0) begin m_ring = 1; m_left = RS; end
            end
        end
        m_phase = (m_mode == 1 || tk) ? 0 : m_phase + 1;
        if (m_mode == 3) begin
            m_mode = 0; m_pos = 0;
        end else if (mgo) begin
            m_mode = (m_mode + 1) % 3; m_pos = 0;
        end else if (pgo) begin
            m_pos = (m_pos + 1) % 3;
        end
        m_time  = nt;
        m_alarm = na;
        @(posedge clk);
        #1;
        i_mode_pls = 1'b0;
        i_pos_pls  = 1'b0;
        i_inc_pls  = 1'b0;
        @(negedge clk);
        dv = disp();
        check("sec",  o_sec,  dv % 60);
        check("min",  o_min,  (dv / 60) % 60);
        check("hour", o_hour, dv / 3600);
        check("mode", o_mode, m_mode);
        check("pos",  o_pos,  m_pos);
        check("ring", o_ring, (m_ring == 1) ? 1 : 0);
    endtask

    // Edit the displayed field set (time in SETUP, alarm in ALARM); starts and ends at pos SEC.
    task automatic set_disp(input int h, input int m, input int s);
        int dv, n;
        dv = disp();
        n = (s - dv % 60 + 60) % 60;
        repeat (n) cycle(0, 0, 1);
        cycle(0, 1, 0);
        n = (m - (dv / 60) % 60 + 60) % 60;
        repeat (n) cycle(0, 0, 1);
        cycle(0, 1, 0);
        n = (h - dv / 3600 + HM + 1) % (HM + 1);
        repeat (n) cycle(0, 0, 1);
        cycle(0, 1, 0);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (o_tick !== 1'b1 && n < 3 * TD) begin cycle(0, 0, 0); n++; end
    endtask

    task automatic wait_ring(output int n);
        n = 0;
        while (o_ring !== 1'b1 && n < 200) begin cycle(0, 0, 0); n++; end
    endtask

    initial begin
        int n, t;
        // Reset state
        #23;
        check("rst_sec", o_sec, 0);
        check("rst_min", o_min, 0);
        check("rst_hour", o_hour, 0);
        check("rst_mode", o_mode, 0);
        check("rst_pos", o_pos, 0);
        check("rst_ring", o_ring, 0);
        check("rst_tick", o_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 240 cycles of free run: 60 ticks, 00:01:00
        t = 0;
        for (int i = 0; i < 240; i++) begin
            if (o_tick === 1'b1) t++;
            cycle(0, 0, 0);
        end
        check("run_ticks", t, 60);
        check("run_sec", o_sec, 0);
        check("run_min", o_min, 1);
        check("run_hour", o_hour, 0);

        // Preload 23:59:58, then two ticks through the full carry chain
        cycle(1, 0, 0);
        set_disp(23, 59, 58);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        wait_tick(n);
        cycle(0, 0, 0);
        check("wrap1_sec", o_sec, 59);
        check("wrap1_hour", o_hour, 23);
        wait_tick(n);
        cycle(0, 0, 0);
        check("wrap2_sec", o_sec, 0);
        check("wrap2_min", o_min, 0);
        check("wrap2_hour", o_hour, 0);

        // SETUP hour edit with wrap, no ticks, then first tick latency
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        t = 0;
        for (int i = 0; i < 25; i++) begin
            if (o_tick === 1'b1) t++;
            cycle(0, 0, 1);
        end
        check("setup_ticks", t, 0);
        check("setup_hour", o_hour, 1);
        check("setup_min", o_min, 0);
        check("setup_sec", o_sec, 0);
        cycle(1, 0, 0);
        wait_tick(n);
        check("first_tick_lat", n, TD - 1);

        // Alarm 00:00:05, run from 00:00:00
        set_disp(0, 0, 5);
        i_alarm_en = 1'b1;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        set_disp(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        wait_ring(n);
        check("ring_rise", o_ring, 1);
        check("ring_sec", o_sec, 5);
        t = 0; n = 0;
        while (o_ring === 1'b1 && n < 100) begin
            if (o_tick === 1'b1) t++;
            cycle(0, 0, 0); n++;
        end
        check("ring_ticks", t, RS);
        check("ring_fall_sec", o_sec, 5 + RS);

        // Disarm mid-ring
        cycle(1, 0, 0);
        set_disp(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        wait_ring(n);
        check("ring2_rise", o_ring, 1);
        cycle(0, 0, 0);
        i_alarm_en = 1'b0;
        cycle(0, 0, 0);
        check("disarm_ring", o_ring, 0);
        i_alarm_en = 1'b1;

        // Mode beats inc in SETUP; forced illegal mode recovers
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        check("prio_mode", o_mode, 2);
        check("prio_asec", o_sec, 5);
        force dut.mode_q = hms_pkg::mode_t'(2'b11);
        #1;
        release dut.mode_q;
        check("illegal_mode", o_mode, 3);
        m_mode = 3;
        cycle(0, 0, 0);
        check("recover_mode", o_mode, 0);

        // Ring action in CLOCK mode
        cycle(1, 0, 0);
        set_disp(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        wait_ring(n);
        check("ring3_rise", o_ring, 1);
        cycle(0, 0, 1);
        check("ring_act", o_ring, 0);
`ifdef HMS_SNOOZE_EN
        t = 0; n = 0;
        while (o_ring !== 1'b1 && n < 400) begin
            if (o_tick === 1'b1) t++;
            cycle(0, 0, 0); n++;
        end
        check("snooze_ticks", t, SM * 60);
        check("snooze_ring", o_ring, 1);
        t = 0; n = 0;
        while (o_ring === 1'b1 && n < 100) begin
            if (o_tick === 1'b1) t++;
            cycle(0, 0, 0); n++;
        end
        check("snooze_ring_ticks", t, RS);
`else
        t = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(0, 0, 0);
            if (o_ring !== 1'b0) t++;
        end
        check("stop_ring_cycles", t, 0);
`endif

        // Random pulses and arming against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) i_alarm_en = ~i_alarm_en;
            cycle($urandom_range(39) == 0, $urandom_range(9) == 0, $urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
